multi_phase_sequencer: RTL and testbench

Parametrised successor to the greenhouse three-phase irrigation/ventilation sequencer. It runs NUM_PHASES timed phases, each with a programmable duration and a per-phase actuator mask driving NUM_ACT actuator outputs. It adds multi-pass repeat, continuous mode, zero-duration phase skipping and a configuration snapshot taken at start. It sits between the control register block and the actuator drivers.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_next_phase.sv | 25 ++
 rtl/multi_phase_sequencer.sv | 151 +++++++++++++++
 tb/tb_multi_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the multi-phase sequencer: FSM state encoding and index-width helper.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_next_phase.sv
// Priority finder: lowest index >= start whose duration-nonzero bit is set.
module seq_next_phase
  import seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned IW = idx_width(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] nz,
  input  logic [IW:0]           start,
  output logic [IW-1:0]         idx,
  output logic                  found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (!found && nz[i] && (i >= 32'(start))) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_phase_sequencer.sv
// Timed multi-phase actuator sequencer with repeat/continuous passes and config snapshot.
// Optional hold input is enabled by defining SEQ_HOLD_EN.
module multi_phase_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned DUR_W      = 8,
  parameter int unsigned NUM_ACT    = 2,
  parameter int unsigned REPEAT_W   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             continuous,
  input  logic [REPEAT_W-1:0]              repeat_count,
  input  logic [NUM_PHASES*DUR_W-1:0]      durations,
  input  logic [NUM_PHASES*NUM_ACT-1:0]    act_mask,
`ifdef SEQ_HOLD_EN
  input  logic                             hold,
`endif
  output logic [NUM_ACT-1:0]               actuators,
  output logic [$clog2(NUM_PHASES)-1:0]    phase_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             pass_done
);

  localparam int unsigned IW = idx_width(NUM_PHASES);

  state_t              state;
  logic [IW-1:0]       phase;
  logic [DUR_W-1:0]    cnt;
  logic [REPEAT_W-1:0] pass_cnt;
  logic [DUR_W-1:0]    dur_q  [NUM_PHASES];
  logic [NUM_ACT-1:0]  mask_q [NUM_PHASES];
  logic [REPEAT_W-1:0] rep_q;
  logic                cont_q;

  logic [NUM_PHASES-1:0] live_nz, snap_nz, first_nz;
  logic [IW-1:0]         first_idx, next_idx;
  logic                  first_found, next_found;
  logic                  hold_act, phase_end, more_passes, pass_end;
  logic [REPEAT_W:0]     eff_rep;

`ifdef SEQ_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  always_comb begin
    live_nz = '0;
    snap_nz = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      live_nz[i] = |durations[i*DUR_W +: DUR_W];
      snap_nz[i] = |dur_q[i];
    end
  end

  // In IDLE the snapshot is being captured on this edge, so search the live durations.
  assign first_nz = (state == IDLE) ? live_nz : snap_nz;

  seq_next_phase #(.NUM_PHASES(NUM_PHASES), .IW(IW)) u_first (
    .nz    (first_nz),
    .start ('0),
    .idx   (first_idx),
    .found (first_found)
  );

  seq_next_phase #(.NUM_PHASES(NUM_PHASES), .IW(IW)) u_next (
    .nz    (snap_nz),
    .start ({1'b0, phase} + (IW+1)'(1)),
    .idx   (next_idx),
    .found (next_found)
  );

  assign phase_end   = (cnt == (dur_q[phase] - DUR_W'(1)));
  assign eff_rep     = (rep_q == '0) ? (REPEAT_W+1)'(1) : {1'b0, rep_q};
  assign more_passes = cont_q || (({1'b0, pass_cnt} + (REPEAT_W+1)'(1)) < eff_rep);
  assign pass_end    = (state == RUN) && enable && !hold_act && phase_end && !next_found;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      phase    <= '0;
      cnt      <= '0;
      pass_cnt <= '0;
      rep_q    <= '0;
      cont_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_PHASES; i++) begin
        dur_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
              dur_q[i]  <= durations[i*DUR_W +: DUR_W];
              mask_q[i] <= act_mask[i*NUM_ACT +: NUM_ACT];
            end
            rep_q    <= repeat_count;
            cont_q   <= continuous;
            cnt      <= '0;
            pass_cnt <= '0;
            if (first_found) begin
              state <= RUN;
              phase <= first_idx;
            end else begin
              state <= DONE;
              phase <= '0;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
            phase <= '0;
            cnt   <= '0;
          end else if (hold_act) begin
            cnt <= cnt;
          end else if (!phase_end) begin
            cnt <= cnt + DUR_W'(1);
          end else if (next_found) begin
            phase <= next_idx;
            cnt   <= '0;
          end else if (more_passes) begin
            phase <= first_idx;
            cnt   <= '0;
            if (pass_cnt != '1) pass_cnt <= pass_cnt + REPEAT_W'(1);
          end else begin
            state <= DONE;
            phase <= '0;
            cnt   <= '0;
          end
        end
        DONE: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign phase_idx = busy ? phase : '0;
  assign actuators = (busy && !hold_act) ? mask_q[phase] : '0;
  assign pass_done = pass_end && reset;

endmodule

// File: tb/tb_multi_phase_sequencer.sv
// Directed self-checking bench for multi_phase_sequencer (default build, hold tied low if present).
module tb_multi_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        continuous;
  logic [3:0]  repeat_count;
  logic [31:0] durations;
  logic [7:0]  act_mask;
  logic [1:0]  actuators;
  logic [1:0]  phase_idx;
  logic        busy, done, pass_done;
`ifdef SEQ_HOLD_EN
  logic        hold = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_phase_sequencer #(
    .NUM_PHASES(4),
    .DUR_W(8),
    .NUM_ACT(2),
    .REPEAT_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .continuous   (continuous),
    .repeat_count (repeat_count),
    .durations    (durations),
    .act_mask     (act_mask),
`ifdef SEQ_HOLD_EN
    .hold         (hold),
`endif
    .actuators    (actuators),
    .phase_idx    (phase_idx),
    .busy         (busy),
    .done         (done),
    .pass_done    (pass_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int b, input int d, input int pd,
                            input int ph, input int act);
    check({tag, ".busy"}, 32'(busy), b);
    check({tag, ".done"}, 32'(done), d);
    check({tag, ".pass_done"}, 32'(pass_done), pd);
    check({tag, ".phase_idx"}, 32'(phase_idx), ph);
    check({tag, ".actuators"}, 32'(actuators), act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ph1  [6] = '{0, 0, 0, 2, 2, 3};
  int act1 [6] = '{1, 1, 1, 2, 2, 3};

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    continuous   = 1'b0;
    repeat_count = 4'd1;
    durations    = '0;
    act_mask     = '0;
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    expect_out("idle", 0, 0, 0, 0, 0);

    // Phase durations 3,0,2,1; masks per phase 01,01,10,11.
    durations = {8'd1, 8'd2, 8'd0, 8'd3};
    act_mask  = {2'b11, 2'b10, 2'b01, 2'b01};
    enable    = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      tick();
      expect_out($sformatf("t1.c%0d", c + 1), 1, 0, (c == 5) ? 1 : 0, ph1[c], act1[c]);
    end
    tick();
    expect_out("t1.done", 0, 1, 0, 0, 0);
    tick();
    expect_out("t1.done_held", 0, 1, 0, 0, 0);
    enable = 1'b0;
    tick();
    expect_out("t1.idle", 0, 0, 0, 0, 0);

    // Two passes over four 1-cycle phases; phase i mask = i.
    repeat_count = 4'd2;
    durations    = {8'd1, 8'd1, 8'd1, 8'd1};
    act_mask     = {2'b11, 2'b10, 2'b01, 2'b00};
    enable       = 1'b1;
    for (int unsigned c = 0; c < 8; c++) begin
      tick();
      expect_out($sformatf("t2.c%0d", c + 1), 1, 0, (c == 3 || c == 7) ? 1 : 0, c % 4, c % 4);
    end
    tick();
    expect_out("t2.done", 0, 1, 0, 0, 0);
    enable = 1'b0;
    tick();

    // Continuous single 2-cycle phase, repeat_count ignored.
    continuous   = 1'b1;
    repeat_count = 4'd1;
    durations    = {8'd0, 8'd0, 8'd0, 8'd2};
    act_mask     = {2'b00, 2'b00, 2'b00, 2'b10};
    enable       = 1'b1;
    for (int unsigned c = 0; c < 20; c++) begin
      tick();
      expect_out($sformatf("t3.c%0d", c + 1), 1, 0, (c % 2 == 1) ? 1 : 0, 0, 2);
    end
    enable = 1'b0;
    tick();
    expect_out("t3.idle", 0, 0, 0, 0, 0);
    continuous = 1'b0;

    // All durations zero -> DONE directly.
    durations = '0;
    enable    = 1'b1;
    tick();
    expect_out("t4.done", 0, 1, 0, 0, 0);
    tick();
    expect_out("t4.done2", 0, 1, 0, 0, 0);
    enable = 1'b0;
    tick();

    // Abort at cycle 2 of a 5-cycle phase, then full re-run.
    durations = {8'd0, 8'd0, 8'd0, 8'd5};
    act_mask  = {2'b00, 2'b00, 2'b00, 2'b11};
    enable    = 1'b1;
    tick();
    expect_out("t5.c1", 1, 0, 0, 0, 3);
    tick();
    expect_out("t5.c2", 1, 0, 0, 0, 3);
    enable = 1'b0;
    tick();
    expect_out("t5.abort", 0, 0, 0, 0, 0);
    enable = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      tick();
      expect_out($sformatf("t5.r%0d", c + 1), 1, 0, (c == 4) ? 1 : 0, 0, 3);
    end
    tick();
    expect_out("t5.done", 0, 1, 0, 0, 0);
    enable = 1'b0;
    tick();
    // Abort exactly on the pass-end cycle suppresses pass_done.
    enable = 1'b1;
    repeat (5) tick();
    check("t5.last_busy", 32'(busy), 1);
    enable = 1'b0;
    #1;
    check("t5.abort_pd", 32'(pass_done), 0);
    tick();
    expect_out("t5.abort_idle", 0, 0, 0, 0, 0);

    // Snapshot isolation: live durations change mid-run.
    durations = {8'd0, 8'd0, 8'd0, 8'd3};
    act_mask  = {2'b00, 2'b00, 2'b00, 2'b01};
    enable    = 1'b1;
    tick();
    expect_out("t6.c1", 1, 0, 0, 0, 1);
    durations = {8'd0, 8'd0, 8'd0, 8'd9};
    act_mask  = {2'b00, 2'b00, 2'b00, 2'b10};
    tick();
    expect_out("t6.c2", 1, 0, 0, 0, 1);
    tick();
    expect_out("t6.c3", 1, 0, 1, 0, 1);
    tick();
    expect_out("t6.done", 0, 1, 0, 0, 0);
    enable = 1'b0;
    tick();
    // Reset mid-run.
    durations = {8'd0, 8'd0, 8'd0, 8'd1};
    enable    = 1'b1;
    tick();
    expect_out("t6.run", 1, 0, 1, 0, 2);
    reset = 1'b0;
    #1;
    check("t6.rst_pd", 32'(pass_done), 0);
    tick();
    expect_out("t6.reset", 0, 0, 0, 0, 0);
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    expect_out("t6.post", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
